// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ready fetches to instruction memory,
// and drives a single registered instruction slot into the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IMEM_AW  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stop,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        ins_out,
    output logic [31:0]        pc_out,
    output logic               fetch_valid
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_SKID  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] stale_addr_reg, stale_addr_next;
    logic [31:0] slot_ins_reg, slot_ins_next;
    logic [31:0] slot_pc_reg, slot_pc_next;
    logic        slot_valid_reg, slot_valid_next;
    logic [31:0] skid_ins_reg, skid_ins_next;
    logic [31:0] skid_pc_reg, skid_pc_next;

    logic        slot_free;
    logic [31:0] pc_inc;
    logic [31:0] redirect_target;
    logic [31:0] addr_sel;
    logic        unused_low_bits;

    assign slot_free       = !slot_valid_reg || !stop;
    assign pc_inc          = pc_reg + 32'd4;
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        stale_addr_next = stale_addr_reg;
        slot_ins_next   = slot_ins_reg;
        slot_pc_next    = slot_pc_reg;
        slot_valid_next = slot_valid_reg;
        skid_ins_next   = skid_ins_reg;
        skid_pc_next    = skid_pc_reg;

        // A consumed slot turns into a bubble unless something refills it below;
        // pc_out deliberately keeps its last value.
        if (!stop) begin
            slot_valid_next = 1'b0;
            slot_ins_next   = 32'd0;
        end

        case (state_reg)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                    if (!imem_ready) begin
                        // Outstanding request must still complete at its original address.
                        state_next      = ST_DROP;
                        stale_addr_next = pc_reg;
                    end
                end else if (imem_ready) begin
                    pc_next = pc_inc;
                    if (slot_free) begin
                        slot_ins_next   = imem_rdata;
                        slot_pc_next    = pc_inc;
                        slot_valid_next = 1'b1;
                    end else begin
                        skid_ins_next = imem_rdata;
                        skid_pc_next  = pc_inc;
                        state_next    = ST_SKID;
                    end
                end
            end
            ST_SKID: begin
                if (redirect_valid) begin
                    pc_next    = redirect_target;
                    state_next = ST_FETCH;
                end else if (!stop) begin
                    slot_ins_next   = skid_ins_reg;
                    slot_pc_next    = skid_pc_reg;
                    slot_valid_next = 1'b1;
                    state_next      = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (redirect_valid) begin
                    pc_next = redirect_target;
                end
                if (imem_ready) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase

        // Flush wins over everything else, including a held slot.
        if (redirect_valid) begin
            slot_valid_next = 1'b0;
            slot_ins_next   = 32'd0;
            skid_ins_next   = 32'd0;
            skid_pc_next    = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= RESET_PC;
            stale_addr_reg <= 32'd0;
            slot_ins_reg   <= 32'd0;
            slot_pc_reg    <= 32'd0;
            slot_valid_reg <= 1'b0;
            skid_ins_reg   <= 32'd0;
            skid_pc_reg    <= 32'd0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            stale_addr_reg <= stale_addr_next;
            slot_ins_reg   <= slot_ins_next;
            slot_pc_reg    <= slot_pc_next;
            slot_valid_reg <= slot_valid_next;
            skid_ins_reg   <= skid_ins_next;
            skid_pc_reg    <= skid_pc_next;
        end
    end

    assign addr_sel = (state_reg == ST_DROP) ? stale_addr_reg : pc_reg;

    // Request and address are forced low while reset is held so memory sees nothing.
    assign imem_req    = reset && (state_reg != ST_SKID);
    assign imem_addr   = reset ? addr_sel[IMEM_AW-1:0] : '0;
    assign ins_out     = slot_ins_reg;
    assign pc_out      = slot_pc_reg;
    assign fetch_valid = slot_valid_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a responder with random latency feeds the DUT and a
// queue-based reference of the fetch stream predicts every output cycle by cycle.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stop = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] ins_out;
    logic [31:0] pc_out;
    logic        fetch_valid;

    fetch_unit #(.RESET_PC(RESET_PC), .IMEM_AW(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .stop           (stop),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .ins_out        (ins_out),
        .pc_out         (pc_out),
        .fetch_valid    (fetch_valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: words fetched on the correct path queue up until the downstream slot takes them.
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } word_t;

    word_t       m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_stale_addr;
    bit          m_stale;
    bit          m_valid;
    logic [31:0] m_ins;
    logic [31:0] m_pcout;

    int wait_cnt;
    int lat;
    int lat_min = 0;
    int lat_max = 0;
    bit req_seen;

    task automatic model_reset();
        m_q.delete();
        m_pc         = RESET_PC;
        m_stale_addr = 32'd0;
        m_stale      = 1'b0;
        m_valid      = 1'b0;
        m_ins        = 32'd0;
        m_pcout      = 32'd0;
        wait_cnt     = 0;
        lat          = int'($urandom_range(lat_max, lat_min));
    endtask

    task automatic model_edge();
        bit    req_exp;
        bit    hs;
        word_t w;
        req_exp = (m_q.size() == 0);
        hs      = req_exp && imem_ready;
        if (redirect_valid) begin
            if (req_exp && !imem_ready && !m_stale) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end else if (hs) begin
                m_stale = 1'b0;
            end
            m_pc = {redirect_pc[31:2], 2'b00};
            m_q.delete();
            m_valid = 1'b0;
            m_ins   = 32'd0;
            $display("[TB] redirect -> %h", m_pc);
        end else begin
            if (hs) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    $display("[TB] discard stale response %h", imem_rdata);
                end else begin
                    w.ins = imem_rdata;
                    w.pc  = m_pc + 32'd4;
                    m_q.push_back(w);
                    $display("[TB] fetch addr=%h data=%h stop=%0d", m_pc, imem_rdata, stop);
                    m_pc = m_pc + 32'd4;
                end
            end
            if (!stop || !m_valid) begin
                if (m_q.size() > 0) begin
                    w       = m_q.pop_front();
                    m_valid = 1'b1;
                    m_ins   = w.ins;
                    m_pcout = w.pc;
                end else begin
                    m_valid = 1'b0;
                    m_ins   = 32'd0;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        bit req_exp;
        req_exp = (m_q.size() == 0);
        check("fetch_valid", 32'(fetch_valid), 32'(m_valid));
        check("ins_out", ins_out, m_ins);
        check("pc_out", pc_out, m_pcout);
        check("imem_req", 32'(imem_req), 32'(req_exp));
        if (req_exp && imem_req)
            check("imem_addr", imem_addr, m_stale ? m_stale_addr : m_pc);
    endtask

    // One clock: drive inputs mid-cycle, let the edge happen, advance the model, compare.
    task automatic step(input bit s, input bit r, input logic [31:0] rpc);
        stop           = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        req_seen       = imem_req;
        imem_ready     = req_seen && (wait_cnt >= lat);
        imem_rdata     = imem_ready ? (imem_addr ^ 32'hA5A5_0000) : $urandom;
        @(posedge clk);
        model_edge();
        if (imem_ready) begin
            wait_cnt = 0;
            lat      = int'($urandom_range(lat_max, lat_min));
        end else if (req_seen) begin
            wait_cnt++;
        end
        #1;
        compare_outputs();
    endtask

    task automatic reset_pulse();
        #2;
        reset          = 1'b0;
        stop           = 1'b0;
        redirect_valid = 1'b0;
        imem_ready     = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_ins_out", ins_out, 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        $display("[TB] reset released");
        compare_outputs();
        check("rst_first_addr", imem_addr, RESET_PC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rpc;
        bit          s;
        bit          r;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("init_imem_req", 32'(imem_req), 32'd0);
        check("init_fetch_valid", 32'(fetch_valid), 32'd0);
        check("init_ins_out", ins_out, 32'd0);
        check("init_pc_out", pc_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare_outputs();
        check("first_addr", imem_addr, 32'h0000_3000);

        // Streaming at zero latency.
        repeat (12) step(1'b0, 1'b0, 32'd0);
        check("stream_pc_out", pc_out, 32'h0000_3030);
        check("stream_ins_out", ins_out, 32'h0000_302C ^ 32'hA5A5_0000);

        // Hold for three cycles while memory keeps answering.
        repeat (3) step(1'b1, 1'b0, 32'd0);
        check("skid_req_low", 32'(imem_req), 32'd0);
        repeat (6) step(1'b0, 1'b0, 32'd0);

        // Latency 3; redirect one cycle after the request goes out.
        lat_min = 3;
        lat_max = 3;
        lat     = 3;
        for (int i = 0; i < 20 && !(imem_req && wait_cnt == 1); i++)
            step(1'b0, 1'b0, 32'd0);
        check("drop_setup", 32'(imem_req && wait_cnt == 1), 32'd1);
        step(1'b0, 1'b1, 32'h0000_4000);
        repeat (8) step(1'b0, 1'b0, 32'd0);

        // Redirect coinciding with a response while stopped.
        lat_min = 0;
        lat_max = 0;
        lat     = 0;
        repeat (4) step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_6000);
        check("redir_flush_valid", 32'(fetch_valid), 32'd0);
        check("redir_addr", imem_addr, 32'h0000_6000);
        repeat (3) step(1'b0, 1'b0, 32'd0);

        // Misaligned target and address wrap.
        step(1'b0, 1'b1, 32'h0000_5003);
        check("align_addr", imem_addr, 32'h0000_5000);
        repeat (2) step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        repeat (2) step(1'b0, 1'b0, 32'd0);
        check("wrap_pc_out", pc_out, 32'd0);
        check("wrap_addr", imem_addr, 32'd0);
        repeat (2) step(1'b0, 1'b0, 32'd0);

        // Reset in the middle of a slow request, then in the middle of a skid hold.
        lat_min = 3;
        lat_max = 3;
        lat     = 3;
        repeat (2) step(1'b0, 1'b0, 32'd0);
        reset_pulse();
        lat_min = 0;
        lat_max = 0;
        lat     = 0;
        repeat (3) step(1'b0, 1'b0, 32'd0);
        repeat (2) step(1'b1, 1'b0, 32'd0);
        check("pre_rst_skid", 32'(imem_req), 32'd0);
        reset_pulse();

        // Random traffic.
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            s = ($urandom_range(99, 0) < 30);
            r = ($urandom_range(99, 0) < 4);
            if ($urandom_range(3, 0) == 0)
                rpc = 32'hFFFF_FFF0 + ($urandom & 32'h0000_000F);
            else
                rpc = 32'h0000_3000 + ($urandom & 32'h0000_03FF);
            if ($urandom_range(999, 0) < 3)
                reset_pulse();
            else
                step(s, r, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that produces the instruction/PC pair consumed by the IF/ID pipeline register. It owns the PC, issues requests to instruction memory over a req/ready handshake, and presents one registered instruction slot downstream. It honours the hazard unit's `stop` (hold) and the branch/jump `redirect` (flush), so no instruction is lost, duplicated or issued down a wrong path.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset.
IMEM_AW, 32, instruction address width (bits [1:0] always 0).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stop  input  1  hazard hold: 1 = downstream register does not capture this edge.
redirect_valid  input  1  branch/jump taken; flush the fetch path.
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0).
imem_req  output  1  request valid; address held stable until imem_ready.
imem_addr  output  32  fetch address.
imem_ready  input  1  response valid this cycle; completes the current request.
imem_rdata  input  32  instruction word, valid with imem_ready.
ins_out  output  32  instruction to the IF/ID register; 0 (NOP) when slot empty.
pc_out  output  32  fetched address + 4 for the instruction in the slot.
fetch_valid  output  1  slot holds a real instruction.

Behaviour:
- Reset (reset=0, async):
  - pc_reg = RESET_PC; state = FETCH.
  - Slot cleared: ins_out = 0, pc_out = 0, fetch_valid = 0. Skid buffer cleared.
  - imem_req = 0 while reset is asserted. After release, imem_req = 1 with imem_addr = RESET_PC in the first cycle.
- The slot is consumed at any edge where stop=0. slot_free = !fetch_valid || !stop.
- The slot holds all of ins_out, pc_out and fetch_valid.

States:
- FETCH
  - Outputs: imem_req = 1, imem_addr = pc_reg.
  - On imem_ready with slot_free: slot <= {imem_rdata, pc_reg+4, 1}; pc_reg += 4; stay in FETCH. Back-to-back requests are allowed, giving 1 instruction/cycle at zero memory latency.
  - On imem_ready with !slot_free: skid <= {imem_rdata, pc_reg+4}; pc_reg += 4; go to SKID.
  - No imem_ready with slot consumed (fetch_valid && !stop): slot becomes a bubble (ins_out = 0, fetch_valid = 0; pc_out holds its last value).
- SKID
  - Outputs: imem_req = 0.
  - When stop=0: slot <= skid; go to FETCH. The next request issues the following cycle.
- DROP
  - Outputs: imem_req = 1, imem_addr = the stale address, held stable per protocol.
  - On imem_ready: discard the response; go to FETCH with pc_reg = the latched redirect target.
- Redirect (highest priority, regardless of stop):
  - Slot and skid cleared (fetch_valid = 0, ins_out = 0) at that edge.
  - pc_reg = {redirect_pc[31:2], 2'b00}.
  - In FETCH with no imem_ready that cycle: go to DROP, because the outstanding request must complete.
  - In FETCH with imem_ready that cycle: the response is discarded; stay in FETCH at the new PC.
  - In SKID: go to FETCH. In DROP: retarget pc_reg and stay in DROP.
- Latency: an instruction appears on ins_out the cycle after its imem_ready edge.
- Arithmetic: PC increment is modulo 2^32 (32'hFFFF_FFFC + 4 = 0). imem_addr[1:0] = 0 always.
- Reset mid-request: the request is abandoned with no DROP; memory must tolerate an abandoned request on reset.
- An instruction is never dropped under stop and never presented twice. Each fetch_valid=1 pair is captured exactly once, by an edge with stop=0.

Test Plan:
- Reset release, imem_ready=1 every cycle, rdata = addr ^ 32'hA5A5_0000 -> imem_addr 3000, 3004, 3008…; ins_out follows one cycle later with pc_out 3004, 3008, ….
- stop=1 for 3 cycles while responses continue -> slot frozen, one word held in SKID, imem_req=0. After stop drops, the sequence resumes with no gap or duplicate address.
- Memory latency 3 cycles; redirect_valid to 32'h0000_4000 issued 1 cycle after the request -> DROP until ready; stale word never reaches ins_out; the next imem_addr is 4000.
- Redirect in the same cycle as imem_ready, with stop=1 -> response discarded, fetch_valid=0, next imem_addr = redirect target.
- redirect_pc = 32'h0000_5003 -> imem_addr 5000; PC at 32'hFFFF_FFFC -> next fetch 0, pc_out 0.
- reset pulsed low mid-request and mid-SKID -> all outputs 0 immediately (async); after release, the first imem_addr is RESET_PC.
